uart_out_collector: RTL
=======================

Name: uart_out_collector

Overview:
- Sits directly downstream of SimTop's UART output (io_uart_out_valid / io_uart_out_ch) in the simulation top.
- Captures every character the DUT emits into a FIFO and drains it to the printer/DPI side via valid/ready.
- Raises a flush request on newline or when output goes idle.
- Detects the good-trap byte (bit7 set), drains pending characters, then signals trap completion so the bench ends only after all output is printed.

Parameters:
DEPTH, 16, FIFO entries; power of two, >=2
IDLE_TIMEOUT, 1000, cycles without a pop before forcing a flush of a partial line
DROP_W, 16, width of the saturating dropped-character counter

Ports:
clock  in  1  sole clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  character strobe from io_uart_out_valid; source cannot stall
in_ch  in  8  character from io_uart_out_ch
out_valid  out  1  FIFO head valid
out_ch  out  7  FIFO head character (bit7 never stored)
out_ready  in  1  consumer accepts head this cycle
flush_req  out  1  one-cycle pulse: consumer must flush its output stream
trap_hit  out  1  sticky: trap byte received
trap_code  out  7  in_ch[6:0] of the trap byte, held
trap_done  out  1  sticky: trap received and FIFO fully drained
overflow  out  1  sticky: at least one character dropped
drop_cnt  out  DROP_W  saturating count of dropped characters
level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync-safe deassert): FIFO empty; every output 0; state RUN; idle counter 0; pending-line flag 0.
- Pop: occurs when out_valid && out_ready. out_ch is the registered FIFO head. A character pushed at cycle N appears on out_valid at N+1 at the earliest.
- Push in RUN: occurs when in_valid && in_ch[7]==0 && (level<DEPTH || pop this cycle). Simultaneous push and pop while full is accepted; level is unchanged.
- Drop: in_valid with in_ch[7]==0 while full and no pop. The character is dropped, overflow is set, and drop_cnt increments, saturating at all-ones.
- Trap: in_valid with in_ch[7]==1 in RUN.
  - The byte is not pushed.
  - trap_hit is set next cycle and trap_code latches in_ch[6:0].
  - State moves to DRAIN.
- DRAIN:
  - All further in_valid is ignored; it is not counted as a drop.
  - Pops continue.
  - When level==0 and no push is pending, go to DONE.
- DONE: trap_done=1; terminal until reset. trap_done asserts the cycle after the FIFO becomes empty in DRAIN.
- Trap arriving while the FIFO is empty: trap_hit and trap_done both assert within 2 cycles of the trap byte.
- A second trap byte is ignored; trap_code keeps its first value.
- Newline flush: when the popped character equals 0x0A, flush_req pulses in the cycle after the pop, and pending-line is cleared.
- Pending-line flag: set by any pop of a non-newline character.
- Idle counter:
  - Clears on any pop; otherwise increments while pending-line==1, saturating at IDLE_TIMEOUT.
  - When it reaches IDLE_TIMEOUT: one flush_req pulse, pending-line cleared, counter cleared.
- Entering DONE with pending-line==1 produces one flush_req pulse in the same cycle trap_done rises.
- flush_req is never high for two consecutive cycles from the same cause; a newline and a timeout in the same cycle give one pulse.
- out_valid must not depend combinationally on out_ready.
- Reset asserted mid-operation: FIFO contents discarded; all sticky flags cleared immediately.

Decomposition:
- Package uart_collector_pkg:
  - state enum {RUN, DRAIN, DONE}
  - constant NEWLINE=7'h0A
  - constant TRAP_BIT=7
- Sub-module uart_out_fifo: a parameterised synchronous FIFO with push/pop, full/empty, level and a registered head. The collector instantiates it once and holds the FSM, the drop/idle counters and the flush logic.

Test Plan:
- Push "hi\n" (0x68,0x69,0x0A) on consecutive cycles, out_ready=1 → out_ch sequence 68,69,0A. flush_req pulses exactly once, the cycle after 0A pops. level returns to 0.
- DEPTH=16, out_ready=0, push 20 chars → level=16, overflow=1, drop_cnt=4. Then out_ready=1 → the first 16 chars drain in order.
- Full FIFO, out_ready=1, push on the same cycle → no drop, level stays 16, drop_cnt unchanged.
- Push "ok" with no newline, then idle with out_ready=1 → flush_req pulses once, IDLE_TIMEOUT cycles after the last pop; no second pulse follows.
- Push 5 chars with out_ready=0, then in_ch=0x80 → trap_hit=1, trap_code=0, trap_done=0. Further input is ignored. After out_ready=1 drains 5 chars, trap_done=1 and flush_req pulses once.
- Assert reset_n=0 mid-drain with level=3 → all outputs 0 asynchronously. After release, the first push appears on out_valid one cycle later.

Source files
------------

// File: rtl/uart_out_collector_pkg.sv
// Shared types and constants for the UART output collector.
// Imported by the collector top and its FIFO.
package uart_collector_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam logic [6:0] NEWLINE  = 7'h0A;
  localparam int         TRAP_BIT = 7;

endpackage

// File: rtl/uart_out_fifo.sv
// Power-of-two synchronous FIFO with occupancy count.
// Head is presented from storage and is zero while empty.
module uart_out_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_o,
  output logic                   valid_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      if (push_i && !pop_i)      cnt_q <= cnt_q + 1'b1;
      else if (!push_i && pop_i) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == FULL);
  assign level_o = cnt_q;
  assign head_o  = valid_o ? mem_q[rd_q] : '0;

endmodule

// File: rtl/uart_out_collector.sv
// Buffers SimTop UART output for the printer side, requests flushes,
// and holds trap completion until every pending character is drained.
module uart_out_collector
  import uart_collector_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int IDLE_TIMEOUT = 1000,
  parameter int DROP_W       = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [7:0]             in_ch,
  output logic                   out_valid,
  output logic [6:0]             out_ch,
  input  logic                   out_ready,
  output logic                   flush_req,
  output logic                   trap_hit,
  output logic [6:0]             trap_code,
  output logic                   trap_done,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic [$clog2(DEPTH):0] level
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  // Fires two counts early so the registered pulse lands
  // IDLE_TIMEOUT cycles after the last pop.
  localparam logic [IW-1:0] IDLE_FIRE = IW'(IDLE_TIMEOUT - 2);

  state_e state_q, state_d;

  logic              full;
  logic              pop;
  logic              push;
  logic              is_trap;
  logic              run;
  logic              char_in;
  logic              drop;
  logic              trap;
  logic              fire;
  logic              done_entry;
  logic              flush_d, flush_q;
  logic              pend_d, pend_q;
  logic [IW-1:0]     idle_d, idle_q;
  logic              hit_q;
  logic [6:0]        code_q;
  logic              ovf_q;
  logic [DROP_W-1:0] drop_q;

  assign pop     = out_valid && out_ready;
  assign is_trap = in_ch[TRAP_BIT];
  assign run     = (state_q == RUN);
  assign char_in = in_valid && !is_trap && run;
  assign push    = char_in && (!full || pop);
  assign drop    = char_in && full && !pop;
  assign trap    = in_valid && is_trap && run;

  uart_out_fifo #(
    .DEPTH (DEPTH),
    .W     (7)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (push),
    .din_i   (in_ch[6:0]),
    .pop_i   (pop),
    .head_o  (out_ch),
    .valid_o (out_valid),
    .full_o  (full),
    .level_o (level)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (trap) state_d = DRAIN;
      DRAIN:   if (level == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    trap_done = (state_q == DONE);
  end

  assign fire       = pend_q && !pop && (idle_q == IDLE_FIRE);
  assign done_entry = (state_q == DRAIN) && (state_d == DONE) && pend_q;

  always_comb begin
    pend_d = pend_q;
    idle_d = idle_q;
    if (pop) begin
      pend_d = (out_ch != NEWLINE);
      idle_d = '0;
    end else if (fire) begin
      pend_d = 1'b0;
      idle_d = '0;
    end else if (pend_q) begin
      idle_d = idle_q + 1'b1;
    end
    if (done_entry) pend_d = 1'b0;
  end

  assign flush_d = (pop && out_ch == NEWLINE) || fire || done_entry;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flush_q <= 1'b0;
      pend_q  <= 1'b0;
      idle_q  <= '0;
      hit_q   <= 1'b0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      flush_q <= flush_d;
      pend_q  <= pend_d;
      idle_q  <= idle_d;
      if (trap) begin
        hit_q  <= 1'b1;
        code_q <= in_ch[6:0];
      end
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign flush_req = flush_q;
  assign trap_hit  = hit_q;
  assign trap_code = code_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

endmodule
